fare_settlement: RTL and testbench

Downstream of the taxi meter. Watches seat and VIP occupancy. When a passenger alights, it captures that source's accumulated fare into a settlement record. Records are queued in a small FIFO and delivered to the receipt printer / logger over a valid/ready handshake, each with a sequence number; a trip counter runs alongside.

---
 rtl/fare_pkg.sv | 33 +++
 rtl/settle_fifo.sv | 47 ++++
 rtl/fare_settlement.sv | 134 +++++++++++++
 tb/tb_fare_settlement.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fare_pkg.sv
// Shared widths, source identifiers and the settlement record layout
// used by the fare settlement block and its record FIFO.
package fare_pkg;

  localparam int COST_W  = 32;
  localparam int SEQ_W   = 16;

  localparam int SRC_SEAT0 = 0;
  localparam int SRC_SEAT1 = 1;
  localparam int SRC_SEAT2 = 2;
  localparam int SRC_SEAT3 = 3;
  localparam int SRC_VIP   = 4;
  localparam int NUM_SRC   = 5;

  typedef struct packed {
    logic [2:0]        src;
    logic [COST_W-1:0] fare;
    logic [SEQ_W-1:0]  seq;
  } settle_rec_t;

  localparam int REC_W = $bits(settle_rec_t);

  // Fixed-priority pick: lowest-numbered set bit wins, 0 when none set.
  function automatic logic [2:0] lowest_set(input logic [NUM_SRC-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/settle_fifo.sv
// Synchronous record FIFO; a push into a full FIFO is accepted when a pop
// happens on the same edge.
module settle_fifo
  import fare_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_income,
  input  logic             push,
  input  logic [REC_W-1:0] wr_data,
  input  logic             pop,
  output logic [REC_W-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset_income) begin
    if (reset_income) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage carries no reset; the head is only observed while non-empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fare_settlement.sv
// Captures each source's fare when its passenger alights, arbitrates pending
// settlements into a record FIFO and hands them out over valid/ready.
module fare_settlement
  import fare_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_income,
  input  logic              seat_0,
  input  logic              seat_1,
  input  logic              seat_2,
  input  logic              seat_3,
  input  logic              vip_enable,
  input  logic [COST_W-1:0] s0cost,
  input  logic [COST_W-1:0] s1cost,
  input  logic [COST_W-1:0] s2cost,
  input  logic [COST_W-1:0] s3cost,
  input  logic [COST_W-1:0] vip_cost,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [2:0]        rec_src,
  output logic [COST_W-1:0] rec_fare,
  output logic [SEQ_W-1:0]  rec_seq,
  output logic [SEQ_W-1:0]  trip_count,
  output logic              overwrite
);

  localparam logic [SEQ_W-1:0] SEQ_ONE = {{(SEQ_W-1){1'b0}}, 1'b1};

  function automatic logic [SEQ_W-1:0] sat_inc(input logic [SEQ_W-1:0] v);
    return (&v) ? v : v + SEQ_ONE;
  endfunction

  logic [NUM_SRC-1:0] occ;
  logic [NUM_SRC-1:0] occ_q;
  logic [NUM_SRC-1:0] alight;
  logic [NUM_SRC-1:0] nonzero;
  logic [NUM_SRC-1:0] event_v;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] grant_mask;
  logic [COST_W-1:0]  cost [NUM_SRC];
  logic [COST_W-1:0]  hold [NUM_SRC];
  logic [SEQ_W-1:0]   seq_q;
  logic [2:0]         grant_idx;
  logic               grant_vld;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               ow_next;
  settle_rec_t        enq_rec;
  settle_rec_t        head;
  logic [REC_W-1:0]   head_bits;

  assign occ = {vip_enable, seat_3, seat_2, seat_1, seat_0};

  always_comb begin
    cost[SRC_SEAT0] = s0cost;
    cost[SRC_SEAT1] = s1cost;
    cost[SRC_SEAT2] = s2cost;
    cost[SRC_SEAT3] = s3cost;
    cost[SRC_VIP]   = vip_cost;
  end

  // Alight = falling occupancy; zero-fare alights never arm a settlement.
  always_comb begin
    nonzero = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      nonzero[i] = (cost[i] != '0);
    end
  end

  assign alight  = occ_q & ~occ;
  assign event_v = alight & nonzero;

  assign rec_valid = !fifo_empty;
  assign pop       = rec_valid && rec_ready;

  // One grant per cycle; a full FIFO still accepts if its head leaves now.
  assign grant_idx  = lowest_set(pending);
  assign grant_vld  = (|pending) && (!fifo_full || pop);
  assign grant_mask = grant_vld ? (NUM_SRC'(1) << grant_idx) : '0;

  // A granted source delivers its old hold, so a same-edge event is not a loss.
  assign ow_next = |(event_v & pending & ~grant_mask);

  always_comb begin
    enq_rec      = '0;
    enq_rec.src  = grant_idx;
    enq_rec.fare = hold[grant_idx];
    enq_rec.seq  = seq_q;
  end

  always_ff @(posedge clock or posedge reset_income) begin
    if (reset_income) begin
      occ_q      <= '0;
      pending    <= '0;
      seq_q      <= '0;
      trip_count <= '0;
      overwrite  <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) hold[i] <= '0;
    end else begin
      occ_q     <= occ;
      pending   <= (pending & ~grant_mask) | event_v;
      overwrite <= ow_next;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (event_v[i]) hold[i] <= cost[i];
      end
      if (grant_vld) begin
        seq_q      <= seq_q + SEQ_ONE;
        trip_count <= sat_inc(trip_count);
      end
    end
  end

  settle_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock        (clock),
    .reset_income (reset_income),
    .push         (grant_vld),
    .wr_data      (enq_rec),
    .pop          (pop),
    .rd_data      (head_bits),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  assign head     = head_bits;
  assign rec_src  = rec_valid ? head.src  : '0;
  assign rec_fare = rec_valid ? head.fare : '0;
  assign rec_seq  = rec_valid ? head.seq  : '0;

endmodule

// File: tb/tb_fare_settlement.sv
// Scoreboard bench for fare_settlement: a queue-based reference model predicts
// settlement records, a monitor compares every record the DUT hands out.
module tb_fare_settlement;
  import fare_pkg::*;

  localparam int DEPTH = 4;

  logic              clock = 1'b0;
  logic              reset_income;
  logic              seat_0, seat_1, seat_2, seat_3, vip_enable;
  logic [COST_W-1:0] s0cost, s1cost, s2cost, s3cost, vip_cost;
  logic              rec_valid;
  logic              rec_ready;
  logic [2:0]        rec_src;
  logic [COST_W-1:0] rec_fare;
  logic [SEQ_W-1:0]  rec_seq;
  logic [SEQ_W-1:0]  trip_count;
  logic              overwrite;

  logic [4:0]        occ;
  logic [COST_W-1:0] cst [5];

  assign seat_0     = occ[0];
  assign seat_1     = occ[1];
  assign seat_2     = occ[2];
  assign seat_3     = occ[3];
  assign vip_enable = occ[4];
  assign s0cost     = cst[0];
  assign s1cost     = cst[1];
  assign s2cost     = cst[2];
  assign s3cost     = cst[3];
  assign vip_cost   = cst[4];

  always #5 clock = ~clock;

  fare_settlement #(.FIFO_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset_income (reset_income),
    .seat_0       (seat_0),
    .seat_1       (seat_1),
    .seat_2       (seat_2),
    .seat_3       (seat_3),
    .vip_enable   (vip_enable),
    .s0cost       (s0cost),
    .s1cost       (s1cost),
    .s2cost       (s2cost),
    .s3cost       (s3cost),
    .vip_cost     (vip_cost),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .rec_src      (rec_src),
    .rec_fare     (rec_fare),
    .rec_seq      (rec_seq),
    .trip_count   (trip_count),
    .overwrite    (overwrite)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: pending settlements per source, FIFO occupancy count,
  // and the ordered list of records the consumer should eventually receive.
  settle_rec_t       exp_q [$];
  bit [4:0]          m_occ_q;
  bit [4:0]          m_pend;
  logic [COST_W-1:0] m_hold [5];
  int                m_cnt;
  int                m_seq;
  int                m_trip;
  bit                m_ow;

  task automatic m_reset();
    m_occ_q = '0;
    m_pend  = '0;
    m_cnt   = 0;
    m_seq   = 0;
    m_trip  = 0;
    m_ow    = 1'b0;
    for (int i = 0; i < 5; i++) m_hold[i] = '0;
    exp_q.delete();
  endtask

  task automatic m_step();
    bit pop_now;
    bit room;
    int g;
    settle_rec_t r;
    pop_now = (m_cnt > 0) && rec_ready;
    room    = (m_cnt < DEPTH) || pop_now;
    m_ow    = 1'b0;
    if (m_pend != 0 && room) begin
      g = 0;
      for (int i = 4; i >= 0; i--) if (m_pend[i]) g = i;
      r.src  = 3'(g);
      r.fare = m_hold[g];
      r.seq  = 16'(m_seq);
      exp_q.push_back(r);
      m_seq = (m_seq + 1) % 65536;
      if (m_trip < 65535) m_trip++;
      m_cnt++;
      m_pend[g] = 1'b0;
    end
    if (pop_now) m_cnt--;
    for (int i = 0; i < 5; i++) begin
      if (m_occ_q[i] && !occ[i] && cst[i] != 0) begin
        if (m_pend[i]) m_ow = 1'b1;
        m_pend[i] = 1'b1;
        m_hold[i] = cst[i];
      end
    end
    m_occ_q = occ;
  endtask

  // Model advances at the falling edge, predicting the next rising edge.
  initial begin
    m_reset();
    forever begin
      @(negedge clock);
      if (reset_income) begin
        m_reset();
      end else begin
        check("rec_valid", rec_valid, (m_cnt > 0));
        check("trip_count", trip_count, m_trip);
        check("overwrite", overwrite, m_ow);
        m_step();
      end
    end
  end

  // Monitor: head must match the oldest expected record; transfers pop it.
  initial begin
    settle_rec_t e;
    forever begin
      @(negedge clock);
      if (!reset_income && rec_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_record", 1, 0);
        end else begin
          e = exp_q[0];
          check("rec_src", rec_src, e.src);
          check("rec_fare", rec_fare, e.fare);
          check("rec_seq", rec_seq, e.seq);
          if (rec_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic alight(input int src, input int fare);
    occ[src] = 1'b1;
    cyc(1);
    cst[src] = COST_W'(fare);
    occ[src] = 1'b0;
    cyc(1);
  endtask

  initial begin
    reset_income = 1'b1;
    occ          = '0;
    rec_ready    = 1'b0;
    for (int i = 0; i < 5; i++) cst[i] = '0;
    #2;
    check("reset_rec_valid", rec_valid, 0);
    check("reset_rec_src", rec_src, 0);
    check("reset_rec_fare", rec_fare, 0);
    check("reset_rec_seq", rec_seq, 0);
    check("reset_trip_count", trip_count, 0);
    check("reset_overwrite", overwrite, 0);
    cyc(2);
    reset_income = 1'b0;

    // Single seat settlement
    rec_ready = 1'b1;
    occ[0] = 1'b1;
    cyc(3);
    cst[0] = 26;
    occ[0] = 1'b0;
    cyc(1);
    check("t1_not_yet_valid", rec_valid, 0);
    cyc(1);
    check("t1_valid", rec_valid, 1);
    cyc(3);
    check("t1_trip", trip_count, 1);

    // Three simultaneous alights
    occ[1] = 1'b1; occ[3] = 1'b1; occ[4] = 1'b1;
    cyc(1);
    cst[1] = 18; cst[3] = 15; cst[4] = 31;
    occ[1] = 1'b0; occ[3] = 1'b0; occ[4] = 1'b0;
    cyc(6);
    check("t2_trip", trip_count, 4);

    // Backpressure: FIFO fills, the rest wait as pending
    rec_ready = 1'b0;
    alight(0, 10); alight(1, 11); alight(2, 12);
    alight(3, 13); alight(4, 14); alight(0, 15);
    cyc(3);
    check("t3_valid_held", rec_valid, 1);
    check("t3_head_fare", rec_fare, 10);
    check("t3_trip_full", trip_count, 8);
    rec_ready = 1'b1;
    cyc(10);
    check("t3_trip", trip_count, 10);

    // Zero fare is dropped
    alight(2, 0);
    cyc(3);
    check("t4_trip", trip_count, 10);
    check("t4_no_record", rec_valid, 0);

    // Overwrite of a still-pending source while the FIFO is full
    rec_ready = 1'b0;
    alight(1, 1); alight(2, 2); alight(3, 3); alight(4, 4);
    alight(0, 20); alight(0, 40);
    cyc(2);
    rec_ready = 1'b1;
    cyc(10);
    check("t5_trip", trip_count, 15);

    // Asynchronous reset with records queued
    rec_ready = 1'b0;
    alight(1, 5); alight(2, 6); alight(3, 7);
    cyc(1);
    reset_income = 1'b1;
    #1;
    check("t6_async_valid", rec_valid, 0);
    check("t6_async_trip", trip_count, 0);
    cyc(1);
    reset_income = 1'b0;
    rec_ready = 1'b1;
    alight(2, 77);
    cyc(4);
    check("t6_trip_after", trip_count, 1);

    // Randomized traffic
    repeat (800) begin
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 3) == 0) occ[i] = ~occ[i];
        cst[i] = ($urandom_range(0, 4) == 0) ? '0 : COST_W'($urandom);
      end
      rec_ready = ($urandom_range(0, 2) != 0);
      cyc(1);
    end

    // Drain with occupancy frozen
    rec_ready = 1'b1;
    for (int n = 0; n < 100 && (exp_q.size() != 0 || m_pend != 0); n++) cyc(1);
    cyc(2);
    check("drain_remaining", exp_q.size(), 0);
    check("drain_valid", rec_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
